// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int MUL_ITERS_DEFAULT = 16;  // radix-4 Booth: 2 multiplier bits per cycle
  localparam int DIV_ITERS_DEFAULT = 32;  // one quotient bit per cycle

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // ALU opcodes the execute stage decodes into ctrl_MULT / ctrl_DIV.
  localparam logic [4:0] MULT = 5'b00110;
  localparam logic [4:0] DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_iterative_if.sv
// Start/ready handshake between the execute stage (master) and the multdiv unit (slave).
interface multdiv_iterative_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_iterative_booth_recoder.sv
// Radix-4 modified Booth recoder: selects {0, +-1, +-2} x multiplicand from 3 multiplier bits.
module booth_recoder (
  input  logic [2:0]  bits,   // {m[i+1], m[i], m[i-1]}
  input  logic [31:0] mcand,
  output logic [33:0] pp      // two's complement, sign-extended to 34 bits
);

  logic [33:0] a1;
  logic [33:0] a2;

  assign a1 = {{2{mcand[31]}}, mcand};
  assign a2 = {a1[32:0], 1'b0};

  // Digit selection; 2x INT_MIN still fits in 34 bits, so negation never wraps.
  always_comb begin
    // NOTE: a default on every path keeps this purely combinational; a missed case would infer a latch.
    pp = '0;
    case (bits)
      3'b001, 3'b010: pp = a1;
      3'b011:         pp = a2;
      3'b100:         pp = -a2;
      3'b101, 3'b110: pp = -a1;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring) unit.
module multdiv_iterative
  import multdiv_pkg::*;
#(
  parameter int MUL_ITERS = MUL_ITERS_DEFAULT,
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input logic              clock,
  input logic              reset,   // asynchronous, active-low
  multdiv_iterative_if.slave bus
);

  localparam int MAX_ITERS = (DIV_ITERS > MUL_ITERS) ? DIV_ITERS : MUL_ITERS;
  localparam int CNT_W     = $clog2(MAX_ITERS) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [32:0]        acc_q, acc_d;     // Booth accumulator, or signed partial remainder
  logic [31:0]        lo_q, lo_d;       // multiplier being shifted out, or dividend/quotient
  logic [31:0]        opb_q, opb_d;     // multiplicand, or divisor magnitude
  logic               guard_q, guard_d; // Booth m[-1] bit
  logic               sign_q, sign_d;   // quotient sign
  logic [31:0]        res_q, res_d;
  logic               exc_q, exc_d;

  // Multiply step datapath.
  logic [33:0] pp;
  logic [33:0] sum;
  logic [32:0] mul_acc_nx;
  logic [31:0] mul_lo_nx;
  logic [32:0] prod_top;
  logic        mul_ovf;

  booth_recoder u_booth (
    .bits  ({lo_q[1:0], guard_q}),
    .mcand (opb_q),
    .pp    (pp)
  );

  assign sum        = {acc_q[32], acc_q} + pp;
  assign mul_acc_nx = {sum[33], sum[33:2]};
  assign mul_lo_nx  = {sum[1:0], lo_q[31:2]};
  // Product bits [63:31] must all match for the product to fit in 32 signed bits.
  assign prod_top   = {mul_acc_nx[31:0], mul_lo_nx[31]};
  assign mul_ovf    = ~((&prod_top) | ~(|prod_top));

  // Divide step datapath: shift remainder left, then subtract or add the divisor by remainder sign.
  logic [32:0] rem_sh;
  logic [32:0] rem_nx;
  logic [31:0] quot_nx;

  assign rem_sh  = {acc_q[31:0], lo_q[31]};
  assign rem_nx  = acc_q[32] ? (rem_sh + {1'b0, opb_q}) : (rem_sh - {1'b0, opb_q});
  assign quot_nx = {lo_q[30:0], ~rem_nx[32]};

  // Operand magnitudes for the divider.
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign abs_a = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

  // Next-state: a start pulse restarts from any state; otherwise iterate and finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    guard_d = guard_q;
    sign_d  = sign_q;
    res_d   = res_q;
    exc_d   = exc_q;

    if (bus.ctrl_MULT) begin
      state_d = S_MUL;
      cnt_d   = '0;
      acc_d   = '0;
      lo_d    = bus.data_operandB;
      opb_d   = bus.data_operandA;
      guard_d = 1'b0;
    end else if (bus.ctrl_DIV) begin
      state_d = S_DIV;
      cnt_d   = '0;
      acc_d   = '0;
      lo_d    = abs_a;
      opb_d   = abs_b;
      sign_d  = bus.data_operandA[31] ^ bus.data_operandB[31];
    end else begin
      case (state_q)
        S_MUL: begin
          acc_d   = mul_acc_nx;
          lo_d    = mul_lo_nx;
          guard_d = lo_q[1];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
            state_d = S_DONE;
            res_d   = mul_lo_nx;
            exc_d   = mul_ovf;
          end
        end
        S_DIV: begin
          acc_d = rem_nx;
          lo_d  = quot_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            state_d = S_DONE;
            // A magnitude of 2^31 with a positive sign only arises from INT_MIN / -1.
            if (opb_q == '0) begin
              res_d = '0;
              exc_d = 1'b1;
            end else begin
              res_d = sign_q ? -quot_nx : quot_nx;
              exc_d = ~sign_q & quot_nx[31];
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      guard_q <= 1'b0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      guard_q <= guard_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_multdiv_iterative.sv
// Self-checking bench for multdiv_iterative: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_multdiv_iterative;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multdiv_iterative_if bus ();

  multdiv_iterative #(.MUL_ITERS(16), .DIV_ITERS(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] last_out;  // {exception, result} the unit should currently be holding

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain 64-bit signed arithmetic; returns {exception, result}.
  function automatic logic [32:0] model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    logic [63:0] rv;
    if (is_mul) begin
      r  = sa * sb;
      rv = r;
      return {(r > 64'sd2147483647) || (r < -64'sd2147483648), rv[31:0]};
    end
    if (sb == 0) return {1'b1, 32'h0};
    r  = sa / sb;
    rv = r;
    return {(r > 64'sd2147483647), rv[31:0]};
  endfunction

  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clk);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Cycle 1 is the cycle right after the start edge. Returns on the negedge of cycle 'window'.
  task automatic watch(input int rdy_cycle, input logic [32:0] exp, input int window, input string tag);
    int first = -1;
    int cnt   = 0;
    logic [31:0] r = '0;
    logic        e = 1'b0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_held"}, bus.data_result, last_out[31:0]);
      if (bus.data_resultRDY === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = c;
          r = bus.data_result;
          e = bus.data_exception;
        end
      end
    end
    check({tag, "_rdy_cycle"}, first, rdy_cycle);
    check({tag, "_rdy_count"}, cnt, 1);
    check({tag, "_result"}, r, exp[31:0]);
    check({tag, "_exc"}, 32'(e), 32'(exp[32]));
    if (window > rdy_cycle) check({tag, "_stable"}, bus.data_result, exp[31:0]);
    last_out = exp;
  endtask

  task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [32:0] exp = model(m, a, b);
    start_op(m, d, a, b);
    watch(m ? 17 : 33, exp, m ? 19 : 35, tag);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 20)) - 32'd10;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int first;
    int cnt;
    logic [31:0] r;
    logic        e;

    rst_n             = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", 32'(bus.data_exception), 32'd0);
    rst_n    = 1'b1;
    last_out = '0;

    // Directed corner cases.
    run(1, 0, 32'd7,         -32'sd3,       "mul_7x-3");
    run(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    run(1, 0, 32'h8000_0000, 32'd1,         "mul_intmin");
    run(0, 1, -32'sd7,       32'd2,         "div_-7/2");
    run(0, 1, 32'd100,       32'd7,         "div_100/7");
    run(0, 1, 32'd12345,     32'd0,         "div_by0");
    run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin/-1");
    run(1, 1, 32'd9,         -32'sd4,       "both_ctrl");

    // Start in the DONE cycle: current RDY is seen, new op begins, held result updates later.
    start_op(1, 0, 32'd7, -32'sd3);
    watch(17, model(1, 32'd7, -32'sd3), 17, "done_a");
    start_op(0, 1, 32'd100, 32'd7);
    watch(33, model(0, 32'd100, 32'd7), 35, "done_b");

    // Random operands.
    for (int i = 0; i < 40; i++) begin
      logic m = 1'($urandom_range(0, 1));
      run(m, ~m, rand_operand(), rand_operand(), m ? "rand_mul" : "rand_div");
    end

    // Abort a divide with a multiply pulse at cycle 10.
    start_op(0, 1, $urandom, $urandom | 32'd1);
    first = -1;
    cnt   = 0;
    r     = '0;
    e     = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = c;
          r = bus.data_result;
          e = bus.data_exception;
        end
      end
      if (c == 10) begin
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd6;
      end
      if (c == 11) bus.ctrl_MULT = 1'b0;
    end
    check("restart_rdy_cycle", first, 27);
    check("restart_rdy_count", cnt, 1);
    check("restart_result", r, 32'd30);
    check("restart_exc", 32'(e), 32'd0);

    // Reset in the middle of a multiply.
    start_op(1, 0, 32'h0001_2345, 32'h0000_6789);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_result", bus.data_result, 32'd0);
    check("midreset_exc", 32'(bus.data_exception), 32'd0);
    check("midreset_rdy", 32'(bus.data_resultRDY), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt   = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) cnt++;
    end
    check("midreset_no_rdy", cnt, 0);
    check("midreset_result_after", bus.data_result, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
